// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - fetch FSM encoding, MIPS opcode constants and IR field positions
package mips_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_e;

  localparam logic [5:0] R_TYPE = 6'b000000;
  localparam logic [5:0] LW     = 6'b100011;
  localparam logic [5:0] SW     = 6'b101011;
  localparam logic [5:0] BEQ    = 6'b000100;
  localparam logic [5:0] J      = 6'b000010;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory, decoder and redirect signals of the fetch unit
interface instr_fetch_if;

  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] pc_out;

  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output mem_rd, mem_addr, dec_valid, opcode, rs, rt, rd, funct, imm, pc_out,
    input  mem_rdata, mem_ack, dec_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_rd, mem_addr, dec_valid, opcode, rs, rt, rd, funct, imm, pc_out,
    output mem_rdata, mem_ack, dec_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_ir_reg.sv
// rtl/fetch_ir_reg.sv - instruction register plus its fetch address, with field slicing
module fetch_ir_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_in,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [31:0] pc_out
);

  logic [31:0] ir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir     <= '0;
      pc_out <= '0;
    end else if (clear) begin
      ir     <= '0;
      pc_out <= '0;
    end else if (load) begin
      ir     <= ir_in;
      pc_out <= pc_in;
    end
  end

  assign opcode = ir[OPCODE_HI:OPCODE_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign funct  = ir[FUNCT_HI:FUNCT_LO];
  assign imm    = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - START/FETCH/ISSUE instruction fetch unit with redirect
// FETCH_PERF_EN adds the instr_count handshake counter port.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  instr_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] instr_count
`endif
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         mem_rd_q;
  logic         dec_valid_q;
  logic         take;
  logic         ir_load;

  assign take    = dec_valid_q && bus.dec_ready;
  // redirect outranks a same-cycle ack, so the word is never captured
  assign ir_load = mem_rd_q && bus.mem_ack && !bus.redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= START;
      pc          <= word_align(RESET_PC);
      mem_rd_q    <= 1'b0;
      dec_valid_q <= 1'b0;
    end else if (bus.redirect) begin
      state       <= FETCH;
      pc          <= word_align(bus.redirect_pc);
      mem_rd_q    <= 1'b1;
      dec_valid_q <= 1'b0;
    end else begin
      case (state)
        START: begin
          state    <= FETCH;
          mem_rd_q <= 1'b1;
        end
        FETCH: begin
          if (bus.mem_ack) begin
            state       <= ISSUE;
            pc          <= pc + 32'd4;
            mem_rd_q    <= 1'b0;
            dec_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (take) begin
            state       <= FETCH;
            mem_rd_q    <= 1'b1;
            dec_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= START;
          mem_rd_q    <= 1'b0;
          dec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = pc;
  assign bus.dec_valid = dec_valid_q;

  fetch_ir_reg u_ir (
    .clk    (clk),
    .reset  (reset),
    .load   (ir_load),
    .clear  (bus.redirect),
    .ir_in  (bus.mem_rdata),
    .pc_in  (pc),
    .opcode (bus.opcode),
    .rs     (bus.rs),
    .rt     (bus.rt),
    .rd     (bus.rd),
    .funct  (bus.funct),
    .imm    (bus.imm),
    .pc_out (bus.pc_out)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= '0;
    end else if (take) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_1000, PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: mem_rd  output  1  instruction-memory read request.
REQ-005 Port: mem_addr  output  32  word-aligned read address; equals pc.
REQ-006 Port: mem_rdata  input  32  instruction word; valid when mem_ack=1.
REQ-007 Port: mem_ack  input  1  read completion; sampled only while mem_rd=1.
REQ-008 Port: dec_valid  output  1  decoder-side instruction valid.
REQ-009 Port: dec_ready  input  1  decoder accepts the presented instruction.
REQ-010 Port: opcode / rs / rt / rd / funct / imm  output  6/5/5/5/6/16  IR[31:26] / [25:21] / [20:16] / [15:11] / [5:0] / [15:0].
REQ-011 Port: pc_out  output  32  address of the instruction currently held in IR.
REQ-012 Port: redirect / redirect_pc  input  1/32  branch or jump target load request and target address.

Function
REQ-013 FSM states: START, FETCH, ISSUE.
- START -> FETCH unconditionally.
- FETCH -> ISSUE on mem_ack.
- ISSUE -> FETCH on dec_valid&&dec_ready.
REQ-014 mem_rd SHALL be 1 exactly when state==FETCH; mem_addr SHALL equal pc in every state.
REQ-015 FETCH with mem_ack=1: IR<=mem_rdata, pc_out<=pc, pc<=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-016 dec_valid SHALL be 1 exactly when state==ISSUE; IR and pc_out SHALL hold stable while dec_valid=1 and dec_ready=0.
REQ-017 Minimum throughput: one instruction per 2 cycles (ack in first FETCH cycle, ready in first ISSUE cycle).
REQ-018 redirect=1 in any state SHALL have the highest priority:
- pc<=redirect_pc with bits [1:0] forced to 0;
- state<=FETCH;
- a same-cycle mem_ack SHALL be discarded;
- a held instruction SHALL be dropped without handshake.
REQ-019 redirect coincident with dec_valid&&dec_ready: the handshake SHALL complete (instruction consumed) and the redirect SHALL still apply.
REQ-020 mem_ack while mem_rd=0 SHALL be ignored.

Reset
REQ-021 On reset assertion, immediately: state=START, pc=RESET_PC, IR=0, pc_out=0, mem_rd=0, dec_valid=0.
REQ-022 Reset asserted mid-fetch or mid-issue SHALL abandon the transaction; the first request after release SHALL be issued to RESET_PC on the second rising edge.

Configuration
REQ-023 Macro: FETCH_PERF_EN.
- Defined: add output port instr_count (32 bits), reset to 0, incremented on each dec_valid&&dec_ready, wrapping at 2^32.
- Undefined: no port and no counter logic.

Structure
REQ-024 Shared package mips_pkg SHALL hold:
- the state encoding;
- opcode constants (R_TYPE=6'b000000, LW=6'b100011, SW=6'b101011, BEQ=6'b000100, J=6'b000010);
- IR field bit positions.
REQ-025 The IR plus pc_out hold register SHALL be one sub-module, fetch_ir_reg: load enable, clear, and field slicing outputs.

Verification
REQ-026 Release reset, mem_ack=1 with rdata=32'h0000_0820, dec_ready=1 -> mem_addr=0x1000, then dec_valid with opcode=0, rs=0, rt=0, rd=1, funct=0x20, pc_out=0x1000; next mem_addr=0x1004.
REQ-027 LW word 32'h8C22_0010 issued, dec_ready held 0 for 5 cycles -> dec_valid stays 1, opcode=6'b100011, imm=0x0010 stable; mem_rd=0 throughout.
REQ-028 redirect=1 with redirect_pc=0x1022 during FETCH, same-cycle ack -> data discarded; next mem_addr=0x1020.
REQ-029 pc=0xFFFF_FFFC fetched and acked -> next mem_addr=0x0000_0000.
REQ-030 Reset asserted while dec_valid=1 -> dec_valid=0 and mem_rd=0 with no clock edge; pc=0x1000 after release.
REQ-031 With FETCH_PERF_EN defined, 10 back-to-back handshakes -> instr_count=10; one redirect-dropped instruction is not counted.
